// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced on a short side path.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] opp_a,
    input  logic [DATA_W-1:0] opp_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPECIAL,
        S_CALC,
        S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic [DATA_W:0]   r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic              w_last;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_fits;
    logic [DATA_W:0]   w_rem_nxt;
    logic [DATA_W-1:0] w_quo_nxt;
    logic [DATA_W-1:0] w_q_fin;
    logic [DATA_W-1:0] w_r_fin;
    logic [DATA_W-1:0] w_calc_res;
    logic [DATA_W-1:0] w_spec_res;

    // op[0]=0 selects the signed variants (DIV/REM)
    assign w_signed  = ~op[0];
    assign w_a_neg   = w_signed & opp_a[DATA_W-1];
    assign w_b_neg   = w_signed & opp_b[DATA_W-1];
    assign w_a_mag   = w_a_neg ? ('0 - opp_a) : opp_a;
    assign w_b_mag   = w_b_neg ? ('0 - opp_b) : opp_b;
    assign w_div0    = (opp_b == '0);
    assign w_ovf     = w_signed && (opp_a == MIN_NEG) && (&opp_b);
    assign w_special = w_div0 | w_ovf;
    assign w_last    = (r_cnt == CNT_W'(1));

    // Shift the next dividend bit in and trial-subtract; the extra top bit is the borrow
    assign w_shift   = (r_rem << 1) | (DATA_W + 1)'(r_quo[DATA_W-1]);
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_fits    = ~w_diff[DATA_W];
    assign w_rem_nxt = w_fits ? w_diff : w_shift;
    assign w_quo_nxt = {r_quo[DATA_W-2:0], w_fits};

    assign w_q_fin    = r_neg_q ? ('0 - w_quo_nxt) : w_quo_nxt;
    assign w_r_fin    = r_neg_r ? ('0 - w_rem_nxt[DATA_W-1:0]) : w_rem_nxt[DATA_W-1:0];
    assign w_calc_res = r_op[1] ? w_r_fin : w_q_fin;

    // On the special path r_quo holds the raw dividend (which is MIN_NEG on overflow)
    assign w_spec_res = r_dz ? (r_op[1] ? r_quo : '1)
                             : (r_op[1] ? '0 : r_quo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = w_special ? S_SPECIAL : S_CALC;
            S_SPECIAL: w_state_nxt = S_DONE;
            S_CALC:    if (w_last) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_dz    <= w_div0;
                        r_rem   <= '0;
                        r_quo   <= w_special ? opp_a : w_a_mag;
                        r_div   <= w_b_mag;
                        r_cnt   <= CNT_W'(DATA_W);
                    end
                end
                S_SPECIAL: r_result <= w_spec_res;
                S_CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) r_result <= w_calc_res;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a cycle-level behavioural model compares busy/done/result every
// cycle, while directed cases pin literal results, latencies, handshake and reset.
module tb_div_unit;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opp_a = '0;
    logic [W-1:0] opp_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .opp_a(opp_a), .opp_b(opp_b),
        .busy(busy), .done(done), .result(result)
    );

    // RISC-V division semantics in plain 64-bit arithmetic
    function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        if (b == '0) return o[1] ? a : '1;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return o[1] ? W'(sa % sb) : W'(sa / sb);
        end
        return o[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) || (!o[0] && a == MINV && b == '1);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: expected outputs for the current cycle
    bit           m_busy = 0, m_done = 0;
    logic [W-1:0] m_result = '0, m_pend = '0;
    int           m_k = 0, m_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_result = '0;
        end
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("result", result, m_result);
        if (!rst) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_k = 1;
                    m_len  = is_special(op, opp_a, opp_b) ? 2 : W + 1;
                    m_pend = ref_res(op, opp_a, opp_b);
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else begin
                m_k++;
                if (m_k == m_len) begin
                    m_done = 1; m_result = m_pend;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int k, output bit got);
        k = 0; got = 0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (done) got = 1;
        end
    endtask

    // Called just after a rising edge with the unit idle; returns just after the edge ending done
    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int k; bit got;
        start = 1; op = o; opp_a = a; opp_b = b;
        tick();
        start = 0; op = 2'($urandom); opp_a = $urandom; opp_b = $urandom;
        wait_done(k, got);
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL %s: no done within 60 cycles", name);
        end else begin
            check({name, "_res"}, result, exp);
            check({name, "_lat"}, 32'(k), 32'(lat));
        end
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return MINV;
            3: return 32'($urandom_range(1, 20));
            4: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k; bit got;

        check("model_divu", ref_res(2'b01, 7, 2), 32'h3);
        check("model_div_neg", ref_res(2'b00, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
        check("model_rem_neg", ref_res(2'b10, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
        check("model_ovf", ref_res(2'b00, MINV, 32'hFFFF_FFFF), MINV);

        tick(); tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", result, 32'h0);
        @(posedge clk); #1 rst = 0;
        tick();

        do_op("divu", 2'b01, 7, 2, 32'h3, 33);
        do_op("remu", 2'b11, 7, 2, 32'h1, 33);
        do_op("div_neg", 2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33);
        do_op("rem_neg", 2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33);
        do_op("rem_negb", 2'b10, 7, 32'hFFFF_FFFE, 32'h1, 33);
        do_op("div_by0", 2'b00, 5, 0, 32'hFFFF_FFFF, 2);
        do_op("remu_by0", 2'b11, 5, 0, 32'h5, 2);
        do_op("div_ovf", 2'b00, MINV, 32'hFFFF_FFFF, MINV, 2);
        do_op("rem_ovf", 2'b10, MINV, 32'hFFFF_FFFF, 32'h0, 2);

        // A start pulse mid-operation must be ignored
        start = 1; op = 2'b01; opp_a = 32'hFFFF_FFFF; opp_b = 32'h10;
        tick();
        start = 0;
        repeat (9) tick();
        start = 1; op = 2'b00; opp_a = 1; opp_b = 0;
        tick();
        start = 0;
        wait_done(k, got);
        if (!got) begin
            n_checks++; n_err++;
            $display("FAIL hs: no done within 60 cycles");
        end else begin
            check("hs_res", result, 32'h0FFF_FFFF);
            check("hs_lat", 32'(k + 10), 32'd33);
        end
        tick();
        do_op("hs_b2b", 2'b01, 100, 7, 32'd14, 33);

        // Reset in the middle of an operation
        start = 1; op = 2'b01; opp_a = 1000; opp_b = 3;
        tick();
        start = 0;
        repeat (14) tick();
        rst = 1;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_result", result, 32'h0);
        tick();
        rst = 0;
        got = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("arst_no_done", 32'(got), 32'h0);
        tick();
        do_op("post_rst", 2'b01, 1000, 3, 32'd333, 33);

        // Random traffic, including starts while busy and in the done cycle
        repeat (3000) begin
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            opp_a = pick();
            opp_b = pick();
            tick();
        end
        start = 0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative multi-cycle integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions.
- It is the multi-cycle counterpart to the single-cycle ALU in the execute stage: it takes the same operand pair plus a divide op, and returns one result word.
- The execute stage stalls while busy is high.
- Restoring algorithm, one quotient bit per cycle.

Parameters:
DATA_W, 32, operand/result width in bits (≥ 2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (instr funct3[1:0])
opp_a  input  DATA_W  dividend, sampled on accepted start
opp_b  input  DATA_W  divisor, sampled on accepted start
busy  output  1  high from cycle after accepted start through done cycle
done  output  1  one-cycle pulse, result valid
result  output  DATA_W  quotient or remainder per op; held until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0; in-flight op discarded, no done produced.
- States:
  - IDLE: start=1 → capture op, |a|, |b|, sign flags; next state is SPECIAL if opp_b==0 or (signed op and a==MIN_NEG and b==all-ones), else CALC with counter=DATA_W.
  - SPECIAL: one cycle, then DONE.
  - CALC: per cycle, shift {rem,quo} left 1 and try rem−divisor; if non-negative keep it and set quo LSB=1. Decrement counter; at counter==1 → DONE.
  - DONE: done=1, busy=1, result registered; next IDLE.
- Latency (start accepted in cycle 0):
  - normal path: done in cycle DATA_W+1 (cycle 33 at default);
  - special path: done in cycle 2.
  - Back-to-back: new start is accepted in the cycle after done (IDLE).
- start while busy=1: ignored, no effect on state or operands. start in the DONE cycle is also ignored.
- Sign rules, signed ops only:
  - operands converted to magnitude before iteration;
  - quotient negated if sign(a)≠sign(b);
  - remainder takes sign of dividend.
  - Unsigned ops use raw operands.
- Special results (RISC-V defined, no trap):
  - divide by zero: DIV/DIVU → all-ones, REM/REMU → opp_a unchanged;
  - signed overflow (MIN_NEG / −1): DIV → MIN_NEG, REM → 0.
- Widths: internal remainder register DATA_W+1 bits for the subtract compare. All arithmetic modulo 2^DATA_W; no overflow flag.
- result changes only on the DONE-state update or reset; it is stable while busy and while idle.
- Operand inputs may change freely after the accepted start cycle without affecting the result.

Test Plan:
- DIVU a=7, b=2, start at cycle 0 → busy=1 cycles 1..33, done=1 only at cycle 33, result=0x00000003. Repeat with REMU → 0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → result 0xFFFFFFFD (−3). REM → 0xFFFFFFFF (−1). REM a=7, b=0xFFFFFFFE → 0x00000001.
- Divide by zero, DIV a=5, b=0 → done at cycle 2, result 0xFFFFFFFF. Same with REMU → 0x00000005.
- Overflow, DIV a=0x80000000, b=0xFFFFFFFF → done at cycle 2, result 0x80000000. REM → 0x00000000.
- Handshake:
  - start DIVU 0xFFFFFFFF/0x10; pulse start with other operands at cycle 10 → ignored, result 0x0FFFFFFF at cycle 33;
  - start again at cycle 34 → accepted.
- Reset mid-operation: assert rst at cycle 15 of a DIVU → busy, done and result go to 0 immediately (async). No done afterwards. A fresh start after rst deasserts completes normally.
